stack_alu_ext: RTL and testbench



---
 rtl/stack_alu_ext.sv | 153 +++++++++++++++
 tb/tb_stack_alu_ext.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/stack_alu_ext.sv
// rtl/stack_alu_ext.sv - parametrised signed LIFO stack ALU evaluating postfix opcodes
module stack_alu_ext #(
  parameter int N     = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [N-1:0]  input_data,
  input  logic [2:0]    opcode,
  output logic [N-1:0]  output_data,
  output logic          overflow,
  output logic          error,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_DUP  = 3'd1;
  localparam logic [2:0] OP_SWAP = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_PUSH = 3'd6;
  localparam logic [2:0] OP_POP  = 3'd7;

  logic [N-1:0]   stack_q [DEPTH];
  logic [N-1:0]   stack_d [DEPTH];
  logic [CW-1:0]  count_q, count_d;
  logic [N-1:0]   out_q, out_d;
  logic           ovf_q, ovf_d;
  logic           err_q, err_d;

  logic [AW-1:0]  top_idx, sec_idx, push_idx;
  logic [N-1:0]   t_val, s_val;
  logic [2*N-1:0] prod;
  logic [N-1:0]   sum, diff;
  logic           add_ovf, sub_ovf, mul_ovf;
  logic           has1, has2, has_room;

  // Operand fetch and arithmetic results for the two topmost entries
  always_comb begin
    top_idx  = AW'(count_q - CW'(1));
    sec_idx  = AW'(count_q - CW'(2));
    push_idx = AW'(count_q);
    t_val    = stack_q[top_idx];
    s_val    = stack_q[sec_idx];
    has1     = (count_q != '0);
    has2     = (count_q > CW'(1));
    has_room = (count_q < DEPTH_C);
    sum      = s_val + t_val;
    diff     = s_val - t_val;
    // Sign-extended operands make the low 2N bits of the product the signed product
    prod     = {{N{s_val[N-1]}}, s_val} * {{N{t_val[N-1]}}, t_val};
    add_ovf  = (s_val[N-1] == t_val[N-1]) && (sum[N-1] != s_val[N-1]);
    sub_ovf  = (s_val[N-1] != t_val[N-1]) && (diff[N-1] != s_val[N-1]);
    mul_ovf  = (prod[2*N-1:N] != {N{prod[N-1]}});
  end

  // Next-state: accepted ops update stack/count/output; rejected ops only raise error
  always_comb begin
    stack_d = stack_q;
    count_d = count_q;
    out_d   = out_q;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    case (opcode)
      OP_DUP: begin
        if (has1 && has_room) begin
          stack_d[push_idx] = t_val;
          count_d           = count_q + CW'(1);
          out_d             = t_val;
        end else begin
          err_d = 1'b1;
        end
      end
      OP_SWAP: begin
        if (has2) begin
          stack_d[top_idx] = s_val;
          stack_d[sec_idx] = t_val;
          out_d            = s_val;
        end else begin
          err_d = 1'b1;
        end
      end
      OP_SUB, OP_ADD, OP_MUL: begin
        if (has2) begin
          if (opcode == OP_SUB) begin
            out_d = diff;
            ovf_d = sub_ovf;
          end else if (opcode == OP_ADD) begin
            out_d = sum;
            ovf_d = add_ovf;
          end else begin
            out_d = prod[N-1:0];
            ovf_d = mul_ovf;
          end
          stack_d[sec_idx] = out_d;
          count_d          = count_q - CW'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      OP_PUSH: begin
        if (has_room) begin
          stack_d[push_idx] = input_data;
          count_d           = count_q + CW'(1);
          out_d             = input_data;
        end else begin
          err_d = 1'b1;
        end
      end
      OP_POP: begin
        if (has1) begin
          count_d = count_q - CW'(1);
          out_d   = t_val;
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // State registers; reset clears status and output but leaves stack contents alone
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      stack_q <= stack_d;
      count_q <= count_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign output_data = out_q;
  assign overflow    = ovf_q;
  assign error       = err_q;
  assign count       = count_q;
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);

endmodule

// File: tb/tb_stack_alu_ext.sv
// tb/tb_stack_alu_ext.sv - self-checking bench for stack_alu_ext with a queue-based reference model
module tb_stack_alu_ext;

  localparam int N     = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  input_data = '0;
  logic [2:0]    opcode = 3'd0;
  logic [N-1:0]  output_data;
  logic          overflow;
  logic          error;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  stack_alu_ext #(.N(N), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .input_data(input_data), .opcode(opcode),
    .output_data(output_data), .overflow(overflow), .error(error),
    .full(full), .empty(empty), .count(count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: stack as a queue of signed integers, top at the back
  int stk[$];
  int exp_out = 0;
  bit exp_ovf = 1'b0;
  bit exp_err = 1'b0;

  function automatic int wrap(input longint v);
    logic signed [N-1:0] b;
    b = v[N-1:0];
    return int'(b);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input logic [2:0] op, input logic [N-1:0] d);
    longint t, s, res;
    if (r) begin
      stk.delete();
      exp_out = 0;
      exp_ovf = 1'b0;
      exp_err = 1'b0;
      return;
    end
    exp_ovf = 1'b0;
    exp_err = 1'b0;
    case (op)
      3'd1: if (stk.size() >= 1 && stk.size() < DEPTH) begin
              exp_out = stk[$];
              stk.push_back(exp_out);
            end else exp_err = 1'b1;
      3'd2: if (stk.size() >= 2) begin
              t = stk.pop_back();
              s = stk.pop_back();
              stk.push_back(int'(t));
              stk.push_back(int'(s));
              exp_out = int'(s);
            end else exp_err = 1'b1;
      3'd3, 3'd4, 3'd5: if (stk.size() >= 2) begin
              t = stk.pop_back();
              s = stk.pop_back();
              res = (op == 3'd3) ? s - t : (op == 3'd4) ? s + t : s * t;
              exp_out = wrap(res);
              exp_ovf = (res != longint'(exp_out));
              stk.push_back(exp_out);
            end else exp_err = 1'b1;
      3'd6: if (stk.size() < DEPTH) begin
              exp_out = int'($signed(d));
              stk.push_back(exp_out);
            end else exp_err = 1'b1;
      3'd7: if (stk.size() >= 1) exp_out = stk.pop_back();
            else exp_err = 1'b1;
      default: ;
    endcase
  endtask

  // Advance the model on the same edge the DUT samples its inputs
  always @(posedge CLK) model_step(RST, opcode, input_data);

  // Compare every DUT output against the model once per cycle
  always @(negedge CLK) begin
    if (chk_en) begin
      check("output_data", 32'(output_data), 32'(exp_out[N-1:0]));
      check("overflow", 32'(overflow), 32'(exp_ovf));
      check("error", 32'(error), 32'(exp_err));
      check("count", 32'(count), 32'(stk.size()));
      check("full", 32'(full), 32'(stk.size() == DEPTH));
      check("empty", 32'(empty), 32'(stk.size() == 0));
    end
  end

  task automatic apply(input logic r, input logic [2:0] op, input logic [N-1:0] d);
    @(negedge CLK);
    RST        = r;
    opcode     = op;
    input_data = d;
    @(posedge CLK);
    #1;
  endtask

  logic [N-1:0] rd;

  initial begin
    apply(1'b1, 3'd0, '0);
    apply(1'b1, 3'd0, '0);
    chk_en = 1'b1;
    check("lit_rst_count", 32'(count), 32'd0);
    check("lit_rst_out", 32'(output_data), 32'd0);
    check("lit_rst_empty", 32'(empty), 32'd1);

    // Push chain and arithmetic
    apply(1'b0, 3'd6, 16'd14);
    apply(1'b0, 3'd6, 16'd77);
    apply(1'b0, 3'd6, 16'd10);
    apply(1'b0, 3'd6, 16'hFFC4);
    check("lit_push_count", 32'(count), 32'd4);
    check("lit_push_out", 32'(output_data), 32'h0000FFC4);
    apply(1'b0, 3'd4, '0);
    check("lit_add", 32'(output_data), 32'h0000FFCE);
    apply(1'b0, 3'd5, '0);
    check("lit_mul", 32'(output_data), 32'h0000F0F6);
    apply(1'b0, 3'd3, '0);
    check("lit_sub", 32'(output_data), 32'h00000F18);
    check("lit_sub_count", 32'(count), 32'd1);
    apply(1'b0, 3'd7, '0);
    check("lit_pop_empty", 32'(empty), 32'd1);

    // Overflow cases
    apply(1'b0, 3'd6, 16'h7FFF);
    apply(1'b0, 3'd6, 16'h0001);
    apply(1'b0, 3'd4, '0);
    check("lit_add_ovf_out", 32'(output_data), 32'h00008000);
    check("lit_add_ovf", 32'(overflow), 32'd1);
    apply(1'b0, 3'd7, '0);
    apply(1'b0, 3'd6, 16'd300);
    apply(1'b0, 3'd6, 16'd300);
    apply(1'b0, 3'd5, '0);
    check("lit_mul_ovf_out", 32'(output_data), 32'h00005F90);
    check("lit_mul_ovf", 32'(overflow), 32'd1);
    apply(1'b0, 3'd0, '0);
    check("lit_nop_ovf", 32'(overflow), 32'd0);
    apply(1'b0, 3'd7, '0);

    // Stack bounds
    for (int i = 1; i <= 5; i++) apply(1'b0, 3'd6, 16'(i));
    check("lit_full_err", 32'(error), 32'd1);
    check("lit_full_out", 32'(output_data), 32'd4);
    check("lit_full_flag", 32'(full), 32'd1);
    for (int i = 0; i < 5; i++) apply(1'b0, 3'd7, '0);
    check("lit_pop_empty_err", 32'(error), 32'd1);
    check("lit_pop_empty_cnt", 32'(count), 32'd0);
    apply(1'b0, 3'd6, 16'd7);
    apply(1'b0, 3'd4, '0);
    check("lit_add_short_err", 32'(error), 32'd1);
    check("lit_add_short_out", 32'(output_data), 32'd7);
    apply(1'b0, 3'd7, '0);

    // DUP / SWAP
    apply(1'b0, 3'd6, 16'd3);
    apply(1'b0, 3'd6, 16'd9);
    apply(1'b0, 3'd2, '0);
    check("lit_swap", 32'(output_data), 32'd3);
    apply(1'b0, 3'd7, '0);
    check("lit_swap_pop", 32'(output_data), 32'd3);
    apply(1'b0, 3'd1, '0);
    check("lit_dup", 32'(output_data), 32'd9);
    check("lit_dup_count", 32'(count), 32'd2);

    // Reset overrides a push on the same edge
    apply(1'b0, 3'd6, 16'd5);
    apply(1'b1, 3'd6, 16'd11);
    check("lit_rst_mid_count", 32'(count), 32'd0);
    check("lit_rst_mid_out", 32'(output_data), 32'd0);
    check("lit_rst_mid_err", 32'(error), 32'd0);

    // Randomized operation mix with occasional resets
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       rd = 16'h7FFF;
        1:       rd = 16'h8000;
        2:       rd = 16'($urandom_range(0, 40)) - 16'd20;
        default: rd = 16'($urandom);
      endcase
      apply(($urandom_range(0, 63) == 0), 3'($urandom_range(0, 7)), rd);
    end

    @(negedge CLK);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
